// File: rtl/lfsr_multimode_gen.sv
// lfsr_multimode_gen: parametrised Fibonacci/Galois LFSR advancing STEP bits per enable,
// with zero-seed protection, lock-up recovery and a period-length counter.
module lfsr_multimode_gen #(
   parameter int                   BIT_WIDTH = 8,
   parameter logic [BIT_WIDTH-1:0] POLY      = 8'h71,
   parameter bit                   MODE      = 1'b0,
   parameter int                   STEP      = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 load_evt,
   input  logic [BIT_WIDTH-1:0] seed_data,
   output logic                 lfsr_vld,
   output logic [BIT_WIDTH-1:0] lfsr_data,
   output logic                 lfsr_done,
   output logic [BIT_WIDTH-1:0] lfsr_cnt,
   output logic                 seed_err
);
   localparam logic [BIT_WIDTH-1:0] ONES = '1;
   logic [BIT_WIDTH-1:0] state, seed, adv, cnt, safe_seed;
   assign lfsr_data = state;
   assign lfsr_cnt  = cnt;
   assign safe_seed = (seed_data == '0) ? ONES : seed_data;
   always_comb begin
      adv = state;
      for (int i = 0; i < STEP; i++)
         adv = MODE ? ({adv[BIT_WIDTH-2:0], 1'b0} ^ (adv[BIT_WIDTH-1] ? POLY : '0))
                    : {adv[BIT_WIDTH-2:0], adv[BIT_WIDTH-1] ^ (^(adv[BIT_WIDTH-2:0] & POLY[BIT_WIDTH-1:1]))};
   end
   // state==seed marks the start of a period (fresh load or just-completed cycle): count restarts at 1
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ONES;
         seed      <= ONES;
         cnt       <= '0;
         lfsr_vld  <= 1'b0;
         lfsr_done <= 1'b0;
         seed_err  <= 1'b0;
      end else begin
         lfsr_vld  <= enable && !load_evt;
         lfsr_done <= 1'b0;
         seed_err  <= 1'b0;
         if (load_evt) begin
            state    <= safe_seed;
            seed     <= safe_seed;
            cnt      <= '0;
            seed_err <= (seed_data == '0);
         end else if (enable) begin
            if (state == '0) begin
               state    <= ONES;
               cnt      <= '0;
               seed_err <= 1'b1;
            end else begin
               state     <= adv;
               cnt       <= ((state == seed) ? '0 : cnt) + BIT_WIDTH'(1);
               lfsr_done <= (adv == seed);
            end
         end
      end
   end
endmodule

// File: tb/tb_lfsr_multimode_gen.sv
// tb_lfsr_multimode_gen: directed + randomized checks of Fibonacci, Galois, STEP=8 and generator/checker instances.
module tb_lfsr_multimode_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1, en_g = 1'b0, ld_g = 1'b0, en_c = 1'b0, ld_c = 1'b0, en_a = 1'b0, en_s = 1'b0, zl = 1'b0;
   logic [7:0] sd_g = 8'h00, zs = 8'h00;
   logic g_vld, g_done, g_err, c_vld, c_done, c_err, a_vld, a_done, a_err, s_vld, s_done, s_err;
   logic [7:0] g_data, g_cnt, c_data, c_cnt, a_data, a_cnt, s_data, s_cnt;
   int total = 0, passed = 0;
   int m_state, m_seed, m_cnt, m_vld, m_done, m_err, m_closed;
   logic [7:0] fib_exp [5] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
   logic [7:0] gal_exp [4] = '{8'h8F, 8'h6F, 8'hDE, 8'hCD};
   logic [7:0] prev;

   lfsr_multimode_gen gen (.clk(clk), .rst(rst), .enable(en_g), .load_evt(ld_g), .seed_data(sd_g),
      .lfsr_vld(g_vld), .lfsr_data(g_data), .lfsr_done(g_done), .lfsr_cnt(g_cnt), .seed_err(g_err));
   lfsr_multimode_gen chk (.clk(clk), .rst(rst), .enable(en_c), .load_evt(ld_c), .seed_data(g_data),
      .lfsr_vld(c_vld), .lfsr_data(c_data), .lfsr_done(c_done), .lfsr_cnt(c_cnt), .seed_err(c_err));
   lfsr_multimode_gen #(.MODE(1'b1)) gal (.clk(clk), .rst(rst), .enable(en_a), .load_evt(zl), .seed_data(zs),
      .lfsr_vld(a_vld), .lfsr_data(a_data), .lfsr_done(a_done), .lfsr_cnt(a_cnt), .seed_err(a_err));
   lfsr_multimode_gen #(.STEP(8)) s8 (.clk(clk), .rst(rst), .enable(en_s), .load_evt(zl), .seed_data(zs),
      .lfsr_vld(s_vld), .lfsr_data(s_data), .lfsr_done(s_done), .lfsr_cnt(s_cnt), .seed_err(s_err));

   // polynomial x^8+x^6+x^5+x^4+1 as a Fibonacci tap mask: feedback is parity of the tapped bits
   function automatic int fib(int s);
      int fb;
      fb = $countones(s & ((8'h71 >> 1) | 8'h80)) % 2;
      return ((s << 1) & 8'hFF) | fb;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model();
      if (rst) begin
         m_state = 'hFF; m_seed = 'hFF; m_cnt = 0; m_vld = 0; m_done = 0; m_err = 0; m_closed = 0;
      end else if (ld_g) begin
         m_state = (sd_g == 0) ? 'hFF : int'(sd_g);
         m_seed = m_state; m_cnt = 0; m_vld = 0; m_done = 0; m_err = (sd_g == 0); m_closed = 0;
      end else if (en_g) begin
         m_vld = 1;
         if (m_state == 0) begin
            m_state = 'hFF; m_cnt = 0; m_done = 0; m_err = 1; m_closed = 0;
         end else begin
            m_state = fib(m_state);
            m_cnt = m_closed ? 1 : (m_cnt + 1) % 256;
            m_done = (m_state == m_seed);
            m_closed = m_done;
            m_err = 0;
         end
      end else begin
         m_vld = 0; m_done = 0; m_err = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model();
      #1;
      check("gen_data", g_data, m_state);
      check("gen_vld", g_vld, m_vld);
      check("gen_done", g_done, m_done);
      check("gen_cnt", g_cnt, m_cnt);
      check("gen_err", g_err, m_err);
   endtask

   initial begin
      tick();
      tick();
      check("gal_rst_data", a_data, 8'hFF);
      check("gal_rst_flags", {a_vld, a_done, a_err, a_cnt}, 0);
      check("s8_rst_data", s_data, 8'hFF);
      check("s8_rst_flags", {s_vld, s_done, s_err, s_cnt}, 0);
      rst = 1'b0;
      en_g = 1'b1; en_a = 1'b1; en_s = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("fib_seq", g_data, fib_exp[i]);
         if (i < 4) begin
            check("gal_seq", a_data, gal_exp[i]);
            check("gal_vld", a_vld, 1'b1);
         end
         if (i == 0) begin
            check("step8_data", s_data, 8'h0B);
            check("step8_vld", s_vld, 1'b1);
         end
         en_s = 1'b0;
         if (i == 3) en_a = 1'b0;
      end
      tick();
      check("s8_hold", {s_vld, s_data}, {1'b0, 8'h0B});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 256; i++) begin
         tick();
         if (i == 255) check("period_end", {g_done, g_data, g_cnt}, {1'b1, 8'hFF, 8'd255});
         if (i == 256) check("period_restart", {g_done, g_data, g_cnt}, {1'b0, 8'hFE, 8'd1});
      end
      en_g = 1'b0; ld_g = 1'b1; sd_g = 8'h00;
      tick();
      check("zero_seed", {g_err, g_vld, g_data}, {1'b1, 1'b0, 8'hFF});
      en_g = 1'b1; sd_g = 8'h5A;
      tick();
      check("load_wins", {g_err, g_vld, g_data}, {1'b0, 1'b0, 8'h5A});
      ld_g = 1'b0;
      tick();
      check("adv_from_5a", g_data, fib(8'h5A));
      for (int i = 0; i < 600; i++) begin
         en_g = ($urandom_range(0, 3) != 0);
         ld_g = ($urandom_range(0, 31) == 0);
         sd_g = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         tick();
      end
      rst = 1'b1; ld_g = 1'b0;
      tick();
      rst = 1'b0; en_g = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      ld_c = 1'b1;
      for (int i = 0; i < 1001; i++) begin
         prev = g_data;
         tick();
         check("pair_track", c_data, prev);
         ld_c = 1'b0; en_c = 1'b1;
      end
      rst = 1'b1;
      tick();
      check("mid_rst_chk_data", c_data, 8'hFF);
      check("mid_rst_chk_flags", {c_vld, c_done, c_err, c_cnt}, 0);
      rst = 1'b0; en_g = 1'b0; en_c = 1'b0;
      tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
